// File: rtl/nzcv_flag_ctrl_if.sv
// Issue/flag-register bundle between the issue stage and the NZCV flag controller.
// stall_cnt is present only when NZCV_STALL_CNT_EN is defined.
interface nzcv_flag_ctrl_if;
    logic       issue_valid;
    logic       issue_ready;
    logic [3:0] issue_cond;
    logic       issue_s;
    logic [1:0] issue_class;
    logic [3:0] alu_flags;
    logic       shifter_c;
    logic [1:0] mul_nz;
    logic [3:0] nzcv_q;
    logic       cond_pass;
    logic [3:0] nzcv_en;
    logic [3:0] nzcv_d;
    logic       mul_busy;
`ifdef NZCV_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    modport master (
        output issue_valid, issue_cond, issue_s, issue_class,
               alu_flags, shifter_c, mul_nz, nzcv_q,
        input  issue_ready, cond_pass, nzcv_en, nzcv_d, mul_busy
`ifdef NZCV_STALL_CNT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  issue_valid, issue_cond, issue_s, issue_class,
               alu_flags, shifter_c, mul_nz, nzcv_q,
        output issue_ready, cond_pass, nzcv_en, nzcv_d, mul_busy
`ifdef NZCV_STALL_CNT_EN
        , output stall_cnt
`endif
    );
endinterface

// File: rtl/nzcv_flag_ctrl.sv
// NZCV flag controller: condition evaluation with write forwarding, delayed multiply
// flag write and issue stall. Optional stall counter via NZCV_STALL_CNT_EN.
module nzcv_flag_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    nzcv_flag_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, MUL_BUSY} state_t;

    localparam logic [3:0] LAT_M1 = 4'(MUL_LAT - 1);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [3:0] en_reg, en_next;
    logic [3:0] d_reg, d_next;

    logic [3:0] eff_flags;
    logic       n, z, c, v;
    logic       pass;
    logic       ready;
    logic       flag_wr;

    // Forward the write the register will capture on the coming edge.
    assign eff_flags = (en_reg & d_reg) | (~en_reg & bus.nzcv_q);
    assign {n, z, c, v} = eff_flags;

    always_comb begin
        pass = 1'b0;
        case (bus.issue_cond)
            4'h0: pass = z;
            4'h1: pass = ~z;
            4'h2: pass = c;
            4'h3: pass = ~c;
            4'h4: pass = n;
            4'h5: pass = ~n;
            4'h6: pass = v;
            4'h7: pass = ~v;
            4'h8: pass = c & ~z;
            4'h9: pass = ~c | z;
            4'hA: pass = (n == v);
            4'hB: pass = (n != v);
            4'hC: pass = ~z & (n == v);
            4'hD: pass = z | (n != v);
            4'hE: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    // While a multiply is pending only unconditional, non-flag-touching ops may pass.
    assign ready = (state_reg == IDLE) |
                   ((bus.issue_cond == 4'hE) & ~bus.issue_s & (bus.issue_class != 2'b11));

    assign flag_wr = bus.issue_valid & ready & pass &
                     (bus.issue_s | (bus.issue_class == 2'b11));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        en_next    = 4'b0000;
        d_next     = d_reg;
        case (state_reg)
            IDLE: begin
                if (flag_wr) begin
                    case (bus.issue_class)
                        2'b00: begin
                            en_next = 4'b1110;
                            d_next  = {bus.alu_flags[3:2], bus.shifter_c, 1'b0};
                        end
                        2'b10: begin
                            state_next = MUL_BUSY;
                            cnt_next   = LAT_M1;
                        end
                        default: begin
                            en_next = 4'b1111;
                            d_next  = bus.alu_flags;
                        end
                    endcase
                end
            end
            MUL_BUSY: begin
                if (cnt_reg == 4'd0) begin
                    en_next    = 4'b1100;
                    d_next     = {bus.mul_nz, 2'b00};
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            en_reg    <= 4'b0000;
            d_reg     <= 4'b0000;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            en_reg    <= en_next;
            d_reg     <= d_next;
        end
    end

    assign bus.issue_ready = ready;
    assign bus.cond_pass   = pass;
    assign bus.nzcv_en     = en_reg;
    assign bus.nzcv_d      = d_reg;
    assign bus.mul_busy    = (state_reg == MUL_BUSY);

`ifdef NZCV_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= 16'd0;
        end else if (bus.issue_valid & ~ready & (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_nzcv_flag_ctrl.sv
// Randomized bench for nzcv_flag_ctrl against a cycle-indexed reference model,
// with an external NZCV register closing the flag loop.
module tb_nzcv_flag_ctrl;
    localparam int MUL_LAT = 3;
    localparam int N_CYC   = 3000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    nzcv_flag_ctrl_if bus();

    nzcv_flag_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // The NZCV register itself, fed by the controller's EN/D.
    logic [3:0] q_reg = 4'h0;
    assign bus.nzcv_q = q_reg;
    always @(posedge clk) q_reg <= (bus.nzcv_en & bus.nzcv_d) | (~bus.nzcv_en & q_reg);

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: expected register outputs and the cycle a multiply write is due.
    logic [3:0] m_en, m_d;
    bit         m_pend;
    int         m_fire;
    int         m_cyc = 0;
    int         m_stall;

    function automatic bit cond_holds(input logic [3:0] cc, input logic [3:0] f);
        bit fn, fz, fc, fv;
        fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
        case (cc)
            4'h0: return fz;
            4'h1: return !fz;
            4'h2: return fc;
            4'h3: return !fc;
            4'h4: return fn;
            4'h5: return !fn;
            4'h6: return fv;
            4'h7: return !fv;
            4'h8: return fc && !fz;
            4'h9: return !fc || fz;
            4'hA: return fn == fv;
            4'hB: return fn != fv;
            4'hC: return !fz && (fn == fv);
            4'hD: return fz || (fn != fv);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_pass();
        return cond_holds(bus.issue_cond, (m_en & m_d) | (~m_en & q_reg));
    endfunction

    function automatic bit model_ready();
        return !m_pend || (bus.issue_cond == 4'hE && !bus.issue_s && bus.issue_class != 2'b11);
    endfunction

    task automatic model_reset();
        m_en = 4'h0; m_d = 4'h0; m_pend = 1'b0; m_stall = 0;
    endtask

    task automatic model_step();
        bit pass, rdy, acc;
        pass = model_pass();
        rdy  = model_ready();
        acc  = bus.issue_valid && rdy;
        if (bus.issue_valid && !rdy && m_stall < 65535) m_stall++;
        m_en = 4'h0;
        if (m_pend && m_cyc == m_fire) begin
            m_en = 4'b1100;
            m_d  = {bus.mul_nz, 2'b00};
            m_pend = 1'b0;
        end else if (acc && pass && (bus.issue_s || bus.issue_class == 2'b11)) begin
            case (bus.issue_class)
                2'b00: begin
                    m_en = 4'b1110;
                    m_d  = {bus.alu_flags[3:2], bus.shifter_c, 1'b0};
                end
                2'b10: begin
                    m_pend = 1'b1;
                    m_fire = m_cyc + MUL_LAT;
                end
                default: begin
                    m_en = 4'b1111;
                    m_d  = bus.alu_flags;
                end
            endcase
        end
        m_cyc++;
    endtask

    task automatic check_regs(input string sfx);
        check_eq({"nzcv_en", sfx}, 16'(bus.nzcv_en), 16'(m_en));
        check_eq({"nzcv_d", sfx}, 16'(bus.nzcv_d), 16'(m_d));
        check_eq({"mul_busy", sfx}, 16'(bus.mul_busy), 16'(m_pend));
`ifdef NZCV_STALL_CNT_EN
        check_eq({"stall_cnt", sfx}, bus.stall_cnt, 16'(m_stall));
`endif
    endtask

    initial begin
        bus.issue_valid = 1'b0;
        bus.issue_cond  = 4'h0;
        bus.issue_s     = 1'b0;
        bus.issue_class = 2'b00;
        bus.alu_flags   = 4'h0;
        bus.shifter_c   = 1'b0;
        bus.mul_nz      = 2'b00;
        model_reset();
        #7;
        check_regs("_por");
        check_eq("issue_ready_por", 16'(bus.issue_ready), 16'd1);
        rst_n = 1'b1;

        for (int i = 0; i < N_CYC; i++) begin
            #1;
            check_eq("cond_pass", 16'(bus.cond_pass), 16'(model_pass()));
            check_eq("issue_ready", 16'(bus.issue_ready), 16'(model_ready()));
            model_step();
            @(posedge clk);
            #1;
            check_regs("");

            bus.issue_valid = ($urandom_range(0, 3) != 0);
            bus.issue_cond  = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            bus.issue_s     = ($urandom_range(0, 3) != 0);
            bus.issue_class = 2'($urandom_range(0, 3));
            bus.alu_flags   = 4'($urandom_range(0, 15));
            bus.shifter_c   = 1'($urandom_range(0, 1));
            bus.mul_nz      = 2'($urandom_range(0, 3));

            // Periodically launch a flag-setting multiply, then reset one cycle later.
            if (i % 97 == 49) begin
                bus.issue_valid = 1'b1;
                bus.issue_cond  = 4'hE;
                bus.issue_s     = 1'b1;
                bus.issue_class = 2'b10;
            end
            if (i % 97 == 50) begin
                #1 rst_n = 1'b0;
                #1;
                model_reset();
                check_regs("_rst");
                check_eq("issue_ready_rst", 16'(bus.issue_ready), 16'd1);
                rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
